// File: rtl/gslcd_pkg.sv
// Shared types, AXI constants and width helper for the gslcd framebuffer fetch path.
package gslcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StIssue,
        StDrain
    } fetch_state_e;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while (width < 32 && (32'd1 << width) < value) begin
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/gslcd_fetch_sched_if.sv
// M00 AXI read-address and read-data signals used by the fetch scheduler.
interface gslcd_fetch_sched_if #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 32
);
    logic [C_M00_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                      arlen;
    logic                            arvalid;
    logic                            arready;
    logic                            rvalid;
    logic                            rlast;
    logic                            rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rvalid, rlast
    );
endinterface

// File: rtl/gslcd_credit_cnt.sv
// Outstanding-burst and reserved-FIFO-word counters; AR and R events in one cycle net together.
module gslcd_credit_cnt #(
    parameter int unsigned BurstLen = 16,
    parameter int unsigned OutW     = 3,
    parameter int unsigned RsvW     = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ar_done,
    input  logic            r_beat,
    input  logic            r_last,
    output logic [OutW-1:0] outstanding,
    output logic [RsvW-1:0] reserved
);

    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic [RsvW-1:0] reserved_q, reserved_d;

    always_comb begin
        outstanding_d = outstanding_q;
        reserved_d    = reserved_q;
        if (ar_done) begin
            outstanding_d = outstanding_d + OutW'(1);
            reserved_d    = reserved_d + RsvW'(BurstLen);
        end
        // Zero guards keep a stray beat from wrapping the counters.
        if (r_beat && reserved_d != '0) begin
            reserved_d = reserved_d - RsvW'(1);
        end
        if (r_beat && r_last && outstanding_d != '0) begin
            outstanding_d = outstanding_d - OutW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            reserved_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            reserved_q    <= reserved_d;
        end
    end

    assign outstanding = outstanding_q;
    assign reserved    = reserved_q;

endmodule

// File: rtl/gslcd_fetch_sched.sv
// Framebuffer fetch scheduler: issues M00 AXI read bursts only when the pixel FIFO can absorb them.
// Optional page flipping between fb_base0/fb_base1 is enabled by defining GSLCD_FETCH_DBUF_EN.
module gslcd_fetch_sched #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M00_AXI_BURST_LEN  = 16,
    parameter int unsigned C_FRAME_WORDS        = 130560,
    parameter int unsigned C_MAX_OUTSTANDING    = 4,
    parameter int unsigned C_FIFO_CNT_WIDTH     = 10
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            enable,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] fb_base0,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] fb_base1,
    input  logic                            fb_sel,
    input  logic                            frame_start,
    input  logic [C_FIFO_CNT_WIDTH-1:0]     fifo_free,
    input  logic                            underrun_clr,
    gslcd_fetch_sched_if.master             m00_axi,
    output logic                            busy,
    output logic                            underrun,
    output logic                            active_buf
);
    import gslcd_pkg::*;

    localparam int unsigned AW   = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned IdxW = clog2(C_FRAME_WORDS + 1);
    localparam int unsigned OutW = clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned RsvW = clog2(C_MAX_OUTSTANDING * C_M00_AXI_BURST_LEN + 1);

    fetch_state_e    state_q, state_d;
    logic [AW-1:0]   base_q, base_d, araddr_q, araddr_d, sel_base;
    logic [IdxW-1:0] word_idx_q, word_idx_d;
    logic            arvalid_q, arvalid_d, rready_q;
    logic            underrun_q, underrun_d, active_buf_q, active_buf_d, sel_buf;
    logic [OutW-1:0] outstanding;
    logic [RsvW-1:0] reserved;
    logic            ar_done, r_beat, frame_done, can_issue;

`ifdef GSLCD_FETCH_DBUF_EN
    assign sel_buf  = fb_sel;
    assign sel_base = fb_sel ? fb_base1 : fb_base0;
`else
    logic unused_dbuf;
    assign sel_buf     = 1'b0;
    assign sel_base    = fb_base0;
    assign unused_dbuf = ^{fb_base1, fb_sel};
`endif

    assign ar_done    = arvalid_q & m00_axi.arready;
    assign r_beat     = m00_axi.rvalid & rready_q;
    assign frame_done = 32'(word_idx_q) >= C_FRAME_WORDS;
    // FIFO space is compared against words already pledged to in-flight bursts.
    assign can_issue  = (32'(outstanding) < C_MAX_OUTSTANDING) &&
                        (32'(fifo_free) >= 32'(reserved) + C_M00_AXI_BURST_LEN) &&
                        !frame_done;

    gslcd_credit_cnt #(
        .BurstLen (C_M00_AXI_BURST_LEN),
        .OutW     (OutW),
        .RsvW     (RsvW)
    ) u_credit (
        .clk         (m00_axi_aclk),
        .rst_n       (m00_axi_aresetn),
        .ar_done     (ar_done),
        .r_beat      (r_beat),
        .r_last      (m00_axi.rlast),
        .outstanding (outstanding),
        .reserved    (reserved)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        active_buf_d = active_buf_q;
        word_idx_d   = word_idx_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        underrun_d   = underrun_q;
        if (ar_done) begin
            arvalid_d  = 1'b0;
            word_idx_d = word_idx_q + IdxW'(C_M00_AXI_BURST_LEN);
        end
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StWaitFrame;
            end
            StWaitFrame: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (frame_start) begin
                    base_d       = sel_base;
                    active_buf_d = sel_buf;
                    word_idx_d   = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                // A pending address is held until accepted before leaving ISSUE.
                if ((frame_done || !enable) && !arvalid_q) begin
                    state_d = StDrain;
                end else if (enable && !arvalid_q && can_issue) begin
                    arvalid_d = 1'b1;
                    araddr_d  = base_q + (AW'(word_idx_q) << 2);
                end
            end
            StDrain: begin
                if (outstanding == '0) state_d = enable ? StWaitFrame : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (frame_start && (state_q == StIssue || state_q == StDrain)) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q      <= StIdle;
            base_q       <= '0;
            araddr_q     <= '0;
            word_idx_q   <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            underrun_q   <= 1'b0;
            active_buf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            araddr_q     <= araddr_d;
            word_idx_q   <= word_idx_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= 1'b1;
            underrun_q   <= underrun_d;
            active_buf_q <= active_buf_d;
        end
    end

    assign m00_axi.araddr  = araddr_q;
    assign m00_axi.arlen   = 8'(C_M00_AXI_BURST_LEN - 1);
    assign m00_axi.arvalid = arvalid_q;
    assign m00_axi.rready  = rready_q;
    assign busy            = (state_q == StIssue) || (state_q == StDrain);
    assign underrun        = underrun_q;
    assign active_buf      = active_buf_q;

endmodule
